// File: rtl/poly_song_reader.sv
// poly_song_reader
//
// Steps through note entries in an external synchronous song ROM and hands
// them to a bank of NUM_VOICES note players. Entries with adv=0 are chord
// members: they are issued back to back on successive voices. An entry with
// adv=1 closes a chord and holds the sequence for 'dur' beat ticks. An entry
// with adv=1 and dur=0 marks the end of the song. Overflow of the entry
// index also ends the song. In loop mode the song restarts from entry 0.
//
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   play        - level, 1 = run, 0 = pause
//   loop        - level, 1 = restart the song at its end
//   song        - song select, captured when leaving PAUSED
//   beat        - one-cycle beat tick
//   rom_addr    - {song_q, idx}, combinational from registers
//   rom_data    - {adv, note, dur, meta}, valid one cycle after rom_addr
//   new_note    - one-cycle pulse, voice/note/duration/meta valid
//   voice       - target note player index
//   note, duration, meta - registered fields of the issued entry
//   song_done   - one-cycle pulse at the end of the song
//   playing     - high while not PAUSED and not DONE
module poly_song_reader #(
    parameter int SONG_BITS  = 2,
    parameter int ADDR_BITS  = 5,
    parameter int NOTE_W     = 6,
    parameter int DUR_W      = 6,
    parameter int META_W     = 3,
    parameter int NUM_VOICES = 3,
    localparam int VOICE_W   = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1,
    localparam int ENTRY_W   = 1 + NOTE_W + DUR_W + META_W
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           play,
    input  logic                           loop,
    input  logic [SONG_BITS-1:0]           song,
    input  logic                           beat,
    output logic [SONG_BITS+ADDR_BITS-1:0] rom_addr,
    input  logic [ENTRY_W-1:0]             rom_data,
    output logic                           new_note,
    output logic [VOICE_W-1:0]             voice,
    output logic [NOTE_W-1:0]              note,
    output logic [DUR_W-1:0]               duration,
    output logic [META_W-1:0]              meta,
    output logic                           song_done,
    output logic                           playing
);

    typedef enum logic [2:0] {
        S_PAUSED,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_INCR,
        S_DONE
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [SONG_BITS-1:0] song_q;
    logic [ADDR_BITS-1:0] idx;
    logic [DUR_W-1:0]     count;
    logic [VOICE_W-1:0]   vcnt;

    // Entry field decode
    logic                 rom_adv;
    logic [NOTE_W-1:0]    rom_note;
    logic [DUR_W-1:0]     rom_dur;
    logic [META_W-1:0]    rom_meta;
    logic                 is_end;
    logic                 idx_last;

    assign rom_adv  = rom_data[ENTRY_W-1];
    assign rom_note = rom_data[ENTRY_W-2 -: NOTE_W];
    assign rom_dur  = rom_data[META_W +: DUR_W];
    assign rom_meta = rom_data[META_W-1:0];
    assign is_end   = rom_adv && (rom_dur == '0);
    assign idx_last = (idx == {ADDR_BITS{1'b1}});

    assign rom_addr = {song_q, idx};
    assign playing  = (state_q != S_PAUSED) && (state_q != S_DONE);

    // Round-robin voice allocation for chord members
    function automatic logic [VOICE_W-1:0] next_voice(input logic [VOICE_W-1:0] v);
        if (v == VOICE_W'(NUM_VOICES - 1))
            return '0;
        else
            return v + 1'b1;
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_PAUSED: begin
                if (play)
                    state_d = S_FETCH;
            end
            S_FETCH: begin
                state_d = play ? S_ISSUE : S_PAUSED;
            end
            S_ISSUE: begin
                // The end marker decides between restart and stop on its own;
                // loop && play is false whenever play has dropped.
                if (is_end)
                    state_d = (loop && play) ? S_FETCH : S_DONE;
                else if (!play)
                    state_d = S_PAUSED;
                else
                    state_d = rom_adv ? S_WAIT : S_INCR;
            end
            S_WAIT: begin
                if (!play)
                    state_d = S_PAUSED;
                else if (beat && (count == DUR_W'(1)))
                    state_d = S_INCR;
            end
            S_INCR: begin
                if (idx_last)
                    state_d = (loop && play) ? S_FETCH : S_DONE;
                else
                    state_d = play ? S_FETCH : S_PAUSED;
            end
            S_DONE: begin
                if (!play)
                    state_d = S_PAUSED;
            end
            default: state_d = S_PAUSED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_PAUSED;
            song_q    <= '0;
            idx       <= '0;
            count     <= '0;
            vcnt      <= '0;
            new_note  <= 1'b0;
            voice     <= '0;
            note      <= '0;
            duration  <= '0;
            meta      <= '0;
            song_done <= 1'b0;
        end else begin
            state_q   <= state_d;
            new_note  <= 1'b0;
            song_done <= 1'b0;
            case (state_q)
                S_PAUSED: begin
                    if (play) begin
                        song_q <= song;
                        // A different song starts from its first entry;
                        // the same song resumes at the paused entry.
                        if (song != song_q) begin
                            idx  <= '0;
                            vcnt <= '0;
                        end
                    end
                end
                S_ISSUE: begin
                    if (is_end) begin
                        song_done <= 1'b1;
                        idx       <= '0;
                        vcnt      <= '0;
                    end else begin
                        new_note <= 1'b1;
                        voice    <= vcnt;
                        note     <= rom_note;
                        duration <= rom_dur;
                        meta     <= rom_meta;
                        if (rom_adv) begin
                            vcnt  <= '0;
                            count <= rom_dur;
                        end else begin
                            vcnt <= next_voice(vcnt);
                        end
                    end
                end
                S_WAIT: begin
                    // Pausing freezes count; resume reloads it from the ROM.
                    if (play && beat)
                        count <= count - 1'b1;
                end
                S_INCR: begin
                    idx <= idx + 1'b1;
                    if (idx_last) begin
                        song_done <= 1'b1;
                        vcnt      <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_poly_song_reader.sv
module tb_poly_song_reader;

    logic        clk;
    int          n_checks;
    int          n_errors;

    // DUT A: default parameters (3 voices)
    logic        reset_a, play_a, loop_a, beat_a;
    logic [1:0]  song_a;
    logic [6:0]  rom_addr_a;
    logic [15:0] rom_data_a;
    logic        new_note_a, done_a, playing_a;
    logic [1:0]  voice_a;
    logic [5:0]  note_a, dur_a;
    logic [2:0]  meta_a;

    // DUT B: two voices
    logic        reset_b, play_b, loop_b, beat_b;
    logic [1:0]  song_b;
    logic [6:0]  rom_addr_b;
    logic [15:0] rom_data_b;
    logic        new_note_b, done_b, playing_b;
    logic [0:0]  voice_b;
    logic [5:0]  note_b, dur_b;
    logic [2:0]  meta_b;

    logic [15:0] rom_a [0:127];
    logic [15:0] rom_b [0:127];

    poly_song_reader dut_a (
        .clk(clk), .reset(reset_a), .play(play_a), .loop(loop_a), .song(song_a),
        .beat(beat_a), .rom_addr(rom_addr_a), .rom_data(rom_data_a),
        .new_note(new_note_a), .voice(voice_a), .note(note_a), .duration(dur_a),
        .meta(meta_a), .song_done(done_a), .playing(playing_a)
    );

    poly_song_reader #(.NUM_VOICES(2)) dut_b (
        .clk(clk), .reset(reset_b), .play(play_b), .loop(loop_b), .song(song_b),
        .beat(beat_b), .rom_addr(rom_addr_b), .rom_data(rom_data_b),
        .new_note(new_note_b), .voice(voice_b), .note(note_b), .duration(dur_b),
        .meta(meta_b), .song_done(done_b), .playing(playing_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous song ROMs: data one cycle after address
    always_ff @(posedge clk) begin
        rom_data_a <= rom_a[rom_addr_a];
        rom_data_b <= rom_b[rom_addr_b];
    end

    function automatic logic [15:0] ent(input int adv, input int n, input int d, input int m);
        logic [15:0] e;
        e = {adv[0], n[5:0], d[5:0], m[2:0]};
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // new_note and song_done must never coincide
    always @(negedge clk) begin
        if (!reset_a) begin
            n_checks++;
            if (new_note_a && done_a) begin
                n_errors++;
                $display("FAIL overlap: new_note=%0d song_done=%0d required not both 1", new_note_a, done_a);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic play;
        logic beat;
        logic nn;
        int   voice;
        int   note;
        int   dur;
        int   meta;
        logic done;
        logic playing;
    } vec_t;

    vec_t tbl [25];

    initial begin
        int first_done, renote, rn_note, rn_voice, ndone, nn_cnt, last_note, done_k;

        n_checks = 0;
        n_errors = 0;

        for (int i = 0; i < 128; i++) begin
            rom_a[i] = ent(1, 0, 0, 0);
            rom_b[i] = ent(1, 0, 0, 0);
        end
        // Song 0: two chord members then a closing note, then end
        rom_a[0]  = ent(0, 10, 4, 1);
        rom_a[1]  = ent(0, 14, 4, 2);
        rom_a[2]  = ent(1, 17, 2, 3);
        // Song 1: 32 single-beat notes, no end marker
        for (int i = 0; i < 32; i++) rom_a[32 + i] = ent(1, i, 1, i % 8);
        // Song 2
        rom_a[64] = ent(1, 33, 3, 5);
        // Song 3: two 3-beat notes then end
        rom_a[96] = ent(1, 20, 3, 1);
        rom_a[97] = ent(1, 21, 3, 2);
        // DUT B song 0: three chord members then a 5-beat note
        rom_b[0]  = ent(0, 1, 2, 0);
        rom_b[1]  = ent(0, 2, 2, 0);
        rom_b[2]  = ent(0, 3, 2, 0);
        rom_b[3]  = ent(1, 4, 5, 7);

        // Song 0 cycle table: play in cycle 0, beat every 8 cycles
        for (int c = 0; c < 25; c++) begin
            tbl[c].play    = 1'b1;
            tbl[c].beat    = (c % 8 == 3);
            tbl[c].nn      = (c == 3 || c == 6 || c == 9);
            tbl[c].note    = (c < 3) ? 0 : (c < 6) ? 10 : (c < 9) ? 14 : 17;
            tbl[c].voice   = (c < 6) ? 0 : (c < 9) ? 1 : 2;
            tbl[c].dur     = (c < 3) ? 0 : (c < 9) ? 4 : 2;
            tbl[c].meta    = (c < 3) ? 0 : (c < 6) ? 1 : (c < 9) ? 2 : 3;
            tbl[c].done    = (c == 23);
            tbl[c].playing = (c >= 1 && c <= 22);
        end

        reset_a = 1'b1; play_a = 1'b0; loop_a = 1'b0; song_a = 2'd0; beat_a = 1'b0;
        reset_b = 1'b1; play_b = 1'b0; loop_b = 1'b0; song_b = 2'd0; beat_b = 1'b0;
        step();
        step();

        // Reset state
        chk("rst new_note", new_note_a, 0);
        chk("rst voice", voice_a, 0);
        chk("rst note", note_a, 0);
        chk("rst duration", dur_a, 0);
        chk("rst meta", meta_a, 0);
        chk("rst song_done", done_a, 0);
        chk("rst playing", playing_a, 0);
        chk("rst rom_addr", rom_addr_a, 0);

        reset_a = 1'b0;
        step();

        // Song 0, single pass
        for (int c = 0; c < 25; c++) begin
            play_a = tbl[c].play;
            beat_a = tbl[c].beat;
            chk($sformatf("s1 c%0d new_note", c), new_note_a, tbl[c].nn);
            chk($sformatf("s1 c%0d voice", c), voice_a, tbl[c].voice);
            chk($sformatf("s1 c%0d note", c), note_a, tbl[c].note);
            chk($sformatf("s1 c%0d duration", c), dur_a, tbl[c].dur);
            chk($sformatf("s1 c%0d meta", c), meta_a, tbl[c].meta);
            chk($sformatf("s1 c%0d song_done", c), done_a, tbl[c].done);
            chk($sformatf("s1 c%0d playing", c), playing_a, tbl[c].playing);
            step();
        end

        // Loop mode
        play_a = 1'b0; beat_a = 1'b0;
        step();
        loop_a = 1'b1; play_a = 1'b1;
        first_done = -1; renote = -1; rn_note = -1; rn_voice = -1; ndone = 0;
        for (int k = 0; k < 80; k++) begin
            beat_a = (k % 8 == 3);
            if (done_a) begin
                ndone++;
                if (first_done < 0) first_done = k;
            end
            if (new_note_a && first_done >= 0 && renote < 0) begin
                renote   = k;
                rn_note  = note_a;
                rn_voice = voice_a;
            end
            step();
        end
        chk("s2 first song_done cycle", first_done, 23);
        chk("s2 reissue cycle", renote, 25);
        chk("s2 reissue note", rn_note, 10);
        chk("s2 reissue voice", rn_voice, 0);
        chk("s2 song_done repeats", (ndone >= 2), 1);
        play_a = 1'b0; loop_a = 1'b0; beat_a = 1'b0;
        step(); step(); step();
        chk("s2 paused playing", playing_a, 0);

        // Song change 0 -> 2 while paused
        song_a = 2'd2; play_a = 1'b1;
        step();
        chk("s5 rom_addr", rom_addr_a, 64);
        chk("s5 playing", playing_a, 1);
        step(); step();
        chk("s5 new_note", new_note_a, 1);
        chk("s5 note", note_a, 33);
        chk("s5 duration", dur_a, 3);
        chk("s5 meta", meta_a, 5);
        chk("s5 voice", voice_a, 0);
        play_a = 1'b0;
        step(); step();

        // 32 entries without end marker, beat every cycle
        song_a = 2'd1; beat_a = 1'b1; play_a = 1'b1;
        nn_cnt = 0; last_note = -1; done_k = -1;
        for (int k = 0; k < 200 && done_k < 0; k++) begin
            if (new_note_a) begin
                nn_cnt++;
                last_note = note_a;
            end
            if (done_a) done_k = k;
            else step();
        end
        chk("s3 song_done cycle", done_k, 129);
        chk("s3 note count", nn_cnt, 32);
        chk("s3 last note", last_note, 31);
        chk("s3 idx wrapped rom_addr", rom_addr_a, 32);
        chk("s3 playing after end", playing_a, 0);
        beat_a = 1'b0; play_a = 1'b0;
        step();

        // Pause mid-WAIT of entry 1 and resume
        song_a = 2'd3;
        for (int k = 0; k <= 50; k++) begin
            play_a = !(k >= 15 && k < 35);
            beat_a = (k == 5 || k == 6 || k == 7 || k == 13 || k == 40 || k == 41 || k == 45);
            if (k == 3) begin
                chk("s4 e0 new_note", new_note_a, 1);
                chk("s4 e0 note", note_a, 20);
            end
            if (k == 11) begin
                chk("s4 e1 new_note", new_note_a, 1);
                chk("s4 e1 note", note_a, 21);
            end
            if (k >= 16 && k <= 37)
                chk($sformatf("s4 k%0d no new_note", k), new_note_a, 0);
            if (k >= 16 && k <= 35)
                chk($sformatf("s4 k%0d paused", k), playing_a, 0);
            if (k == 38) begin
                chk("s4 reissue new_note", new_note_a, 1);
                chk("s4 reissue note", note_a, 21);
                chk("s4 reissue duration", dur_a, 3);
            end
            if (k >= 42 && k <= 44) begin
                chk($sformatf("s4 k%0d still waiting done", k), done_a, 0);
                chk($sformatf("s4 k%0d still playing", k), playing_a, 1);
            end
            if (k == 49)
                chk("s4 song_done", done_a, 1);
            step();
        end
        play_a = 1'b0; beat_a = 1'b0;

        // Two voices, reset mid-WAIT
        reset_b = 1'b0;
        step();
        for (int k = 0; k <= 17; k++) begin
            play_b = (k < 16);
            reset_b = (k == 15);
            if (k == 3) begin
                chk("s6 n0 new_note", new_note_b, 1);
                chk("s6 n0 voice", voice_b, 0);
                chk("s6 n0 note", note_b, 1);
            end
            if (k == 6) begin
                chk("s6 n1 new_note", new_note_b, 1);
                chk("s6 n1 voice", voice_b, 1);
                chk("s6 n1 note", note_b, 2);
            end
            if (k == 9) begin
                chk("s6 n2 new_note", new_note_b, 1);
                chk("s6 n2 voice", voice_b, 0);
                chk("s6 n2 note", note_b, 3);
            end
            if (k == 12) begin
                chk("s6 n3 voice", voice_b, 1);
                chk("s6 n3 note", note_b, 4);
                chk("s6 n3 meta", meta_b, 7);
            end
            if (k == 14)
                chk("s6 waiting playing", playing_b, 1);
            if (k == 16) begin
                chk("s6 rst new_note", new_note_b, 0);
                chk("s6 rst voice", voice_b, 0);
                chk("s6 rst note", note_b, 0);
                chk("s6 rst duration", dur_b, 0);
                chk("s6 rst meta", meta_b, 0);
                chk("s6 rst song_done", done_b, 0);
                chk("s6 rst playing", playing_b, 0);
                chk("s6 rst rom_addr", rom_addr_b, 0);
            end
            if (k == 17)
                chk("s6 stays paused", playing_b, 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
